car_sprite_plotter: RTL

- Draws the player car sprite onto the 160x120 frame buffer.
- On each START it first erases the car at its previous position by restoring background pixels, then draws the sprite at the new position.
- Reads pixels from the synchronous background ROM and the sprite ROM, and drives x/y/colour/plot into the VGA adapter.
- The screen-level mux hands it the adapter port while the play screen is active.

---
 rtl/car_sprite_plotter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/car_sprite_plotter.sv
// Player car sprite plotter: erases the car at its previous position from the background ROM,
// then draws it at the new position from the sprite ROM. Optional mirror: CAR_SPRITE_FLIP_EN.
module car_sprite_plotter #(
    parameter int unsigned SPRITE_W    = 8,
    parameter int unsigned SPRITE_H    = 12,
    parameter logic [2:0]  TRANSPARENT = 3'b000
) (
    input  logic        CLOCK,
    input  logic        RESETN,
    input  logic        START,
    input  logic [7:0]  NEW_X,
    input  logic [6:0]  NEW_Y,
`ifdef CAR_SPRITE_FLIP_EN
    input  logic        FLIP,
`endif
    output logic [14:0] BG_ADDR,
    input  logic [2:0]  BG_COLOR,
    output logic [7:0]  SPR_ADDR,
    input  logic [2:0]  SPR_COLOR,
    output logic [7:0]  VGA_X,
    output logic [6:0]  VGA_Y,
    output logic [2:0]  COLOUR,
    output logic        PLOT,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_EFLUSH, S_DRAW, S_DFLUSH, S_FIN
    } state_t;

    state_t      state_q;
    logic [3:0]  col_q, row_q;
    logic [7:0]  old_x_q, new_x_q, tx_q;
    logic [6:0]  old_y_q, new_y_q, ty_q;
    logic        old_valid_q, qual_q, erase_q, busy_q, done_q;
    logic        flip_q;

    logic        in_erase, last_px, qual_d;
    logic [7:0]  base_x;
    logic [6:0]  base_y;
    logic [8:0]  tx_d;
    logic [7:0]  ty_d;
    logic [3:0]  spr_col;

    always_comb begin
        in_erase = (state_q == S_ERASE);
        last_px  = (col_q == 4'(SPRITE_W - 1)) && (row_q == 4'(SPRITE_H - 1));
        base_x   = in_erase ? old_x_q : new_x_q;
        base_y   = in_erase ? old_y_q : new_y_q;
        tx_d     = {1'b0, base_x} + {5'b0, col_q};
        ty_d     = {1'b0, base_y} + {4'b0, row_q};
        qual_d   = (tx_d < 9'd160) && (ty_d < 8'd120);
        spr_col  = flip_q ? (4'(SPRITE_W - 1) - col_q) : col_q;
    end

    assign BG_ADDR  = {ty_d[6:0], tx_d[7:0]};
    assign SPR_ADDR = 8'(row_q * SPRITE_W) + {4'b0, spr_col};

    // Plot stage sits one cycle behind the address: ROM data arrives with the registered target.
    assign VGA_X  = tx_q;
    assign VGA_Y  = ty_q;
    assign COLOUR = !qual_q ? '0 : (erase_q ? BG_COLOR : SPR_COLOR);
    assign PLOT   = qual_q && (erase_q || (SPR_COLOR != TRANSPARENT));
    assign BUSY   = busy_q;
    assign DONE   = done_q;

`ifndef CAR_SPRITE_FLIP_EN
    assign flip_q = 1'b0;
`endif

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            old_x_q     <= '0;
            old_y_q     <= '0;
            new_x_q     <= '0;
            new_y_q     <= '0;
            tx_q        <= '0;
            ty_q        <= '0;
            old_valid_q <= 1'b0;
            qual_q      <= 1'b0;
            erase_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef CAR_SPRITE_FLIP_EN
            flip_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    qual_q <= 1'b0;
                    done_q <= 1'b0;
                    if (START) begin
                        new_x_q <= NEW_X;
                        new_y_q <= NEW_Y;
`ifdef CAR_SPRITE_FLIP_EN
                        flip_q  <= FLIP;
`endif
                        col_q   <= '0;
                        row_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= old_valid_q ? S_ERASE : S_DRAW;
                    end
                end
                S_ERASE, S_DRAW: begin
                    tx_q    <= tx_d[7:0];
                    ty_q    <= ty_d[6:0];
                    qual_q  <= qual_d;
                    erase_q <= in_erase;
                    if (last_px) begin
                        col_q   <= '0;
                        row_q   <= '0;
                        state_q <= in_erase ? S_EFLUSH : S_DFLUSH;
                    end else if (col_q == 4'(SPRITE_W - 1)) begin
                        col_q <= '0;
                        row_q <= row_q + 4'd1;
                    end else begin
                        col_q <= col_q + 4'd1;
                    end
                end
                S_EFLUSH: begin
                    qual_q  <= 1'b0;
                    state_q <= S_DRAW;
                end
                S_DFLUSH: begin
                    qual_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_FIN;
                end
                S_FIN: begin
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    old_x_q     <= new_x_q;
                    old_y_q     <= new_y_q;
                    old_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
